// File: rtl/turf_event_fragmenter.sv
// turf_event_fragmenter
// Store-and-forward splitter: buffers up to nfrag+1 qwords of an incoming
// event, then emits one UDP header beat and the buffered payload, repeating
// until the event's tlast has been forwarded. Events seen while the port is
// closed are swallowed and counted.
// Optional feature macro: TURF_FRAG_HEADER_EN prepends a fragment header
// qword to every fragment and counts it in udp_length.
// Handshakes: a beat transfers on a rising aclk edge when tvalid and tready
// are both high; tvalid and tdata are held until then and tvalid never
// looks at tready.
module turf_event_fragmenter #(
   parameter int BUF_DEPTH = 1024
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [63:0] s_evdata_tdata,
   input  logic        s_evdata_tvalid,
   output logic        s_evdata_tready,
   input  logic        s_evdata_tlast,
   output logic [63:0] m_udphdr_tdata,
   output logic        m_udphdr_tvalid,
   input  logic        m_udphdr_tready,
   output logic [63:0] m_udpdata_tdata,
   output logic [7:0]  m_udpdata_tkeep,
   output logic        m_udpdata_tvalid,
   input  logic        m_udpdata_tready,
   output logic        m_udpdata_tlast,
   input  logic [9:0]  nfragment_count_i,
   input  logic [31:0] event_ip_i,
   input  logic [15:0] event_port_i,
   input  logic        event_open_i,
   output logic [15:0] event_number_o,
   output logic [15:0] dropped_events_o
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int CW = AW + 1;
`ifdef TURF_FRAG_HEADER_EN
   localparam logic [15:0] HDR_WORDS = 16'd1;
`else
   localparam logic [15:0] HDR_WORDS = 16'd0;
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FILL    = 3'd1,
      S_HDR     = 3'd2,
`ifdef TURF_FRAG_HEADER_EN
      S_FHDR    = 3'd5,
`endif
      S_PAYLOAD = 3'd3,
      S_DROP    = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [9:0]      r_nfrag;
   logic [31:0]     r_ip;
   logic [15:0]     r_port;
   logic [CW-1:0]   r_wcnt;      // words in current fragment
   logic [CW-1:0]   r_rptr;      // payload words already handed out
   logic [15:0]     r_frag_idx;
   logic            r_last;      // current fragment carries the event's tlast
   logic [15:0]     r_evnum;
   logic [15:0]     r_drop;
   logic [63:0]     r_buf [BUF_DEPTH];
   logic [63:0]     r_rdata;     // registered buffer output, doubles as payload tdata

   logic            w_in_hs;
   logic            w_hdr_hs;
   logic            w_dat_hs;
   logic            w_pay_last;
   logic            w_fill_end;
   logic [AW-1:0]   w_raddr;
   logic [15:0]     w_len_words;

   assign w_in_hs     = s_evdata_tvalid & s_evdata_tready;
   assign w_hdr_hs    = m_udphdr_tvalid & m_udphdr_tready;
   assign w_dat_hs    = m_udpdata_tvalid & m_udpdata_tready;
   assign w_pay_last  = (r_rptr == (r_wcnt - CW'(1)));
   assign w_fill_end  = w_in_hs & (s_evdata_tlast | (r_wcnt == CW'(r_nfrag)));
   assign w_len_words = 16'(r_wcnt) + HDR_WORDS;

   // Read address looks one word ahead on a payload handshake so the next
   // word is already in r_rdata on the following cycle (no bubbles); outside
   // PAYLOAD it parks on word 0 so the first word is primed during HDR.
   assign w_raddr = (r_state == S_PAYLOAD) ?
                    (w_dat_hs ? AW'(r_rptr + CW'(1)) : AW'(r_rptr)) : '0;

   // State register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (s_evdata_tvalid) w_next = event_open_i ? S_FILL : S_DROP;
         S_FILL:    if (w_fill_end) w_next = S_HDR;
`ifdef TURF_FRAG_HEADER_EN
         S_HDR:     if (w_hdr_hs) w_next = S_FHDR;
         S_FHDR:    if (w_dat_hs) w_next = S_PAYLOAD;
`else
         S_HDR:     if (w_hdr_hs) w_next = S_PAYLOAD;
`endif
         S_PAYLOAD: if (w_dat_hs && w_pay_last) w_next = r_last ? S_IDLE : S_FILL;
         S_DROP:    if (w_in_hs && s_evdata_tlast) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // Output decode from state and registered fragment context.
   always_comb begin
      s_evdata_tready  = (r_state == S_FILL) || (r_state == S_DROP);
      m_udphdr_tvalid  = (r_state == S_HDR);
      m_udphdr_tdata   = {r_ip, r_port, w_len_words[12:0], 3'b000};
      m_udpdata_tvalid = (r_state == S_PAYLOAD);
      m_udpdata_tdata  = r_rdata;
      m_udpdata_tlast  = (r_state == S_PAYLOAD) && w_pay_last;
      m_udpdata_tkeep  = 8'hFF;
`ifdef TURF_FRAG_HEADER_EN
      if (r_state == S_FHDR) begin
         m_udpdata_tvalid = 1'b1;
         m_udpdata_tdata  = {r_frag_idx, r_evnum, w_len_words[12:0] - 13'(HDR_WORDS),
                             3'b000, 15'd0, r_last};
      end
`endif
   end

   // Fragment context: config latch, word counting, event/drop counters.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_nfrag    <= '0;
         r_ip       <= '0;
         r_port     <= '0;
         r_wcnt     <= '0;
         r_rptr     <= '0;
         r_frag_idx <= '0;
         r_last     <= 1'b0;
         r_evnum    <= '0;
         r_drop     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (s_evdata_tvalid) begin
               r_nfrag    <= nfragment_count_i;
               r_ip       <= event_ip_i;
               r_port     <= event_port_i;
               r_frag_idx <= '0;
               r_wcnt     <= '0;
            end
            S_FILL: if (w_in_hs) begin
               r_wcnt <= r_wcnt + CW'(1);
               r_last <= s_evdata_tlast;
            end
            S_PAYLOAD: if (w_dat_hs) begin
               r_rptr <= r_rptr + CW'(1);
               if (w_pay_last) begin
                  r_rptr <= '0;
                  if (r_last) begin
                     r_evnum <= r_evnum + 16'd1;
                  end else begin
                     r_frag_idx <= r_frag_idx + 16'd1;
                     r_wcnt     <= '0;
                  end
               end
            end
            S_DROP: if (w_in_hs && s_evdata_tlast) r_drop <= r_drop + 16'd1;
            default: ;
         endcase
      end
   end

   // Fragment buffer: write while filling, synchronous read for payload.
   always_ff @(posedge aclk) begin
      if (r_state == S_FILL && w_in_hs) r_buf[AW'(r_wcnt)] <= s_evdata_tdata;
      r_rdata <= r_buf[w_raddr];
   end

   assign event_number_o   = r_evnum;
   assign dropped_events_o = r_drop;

endmodule

// File: tb/tb_turf_event_fragmenter.sv
// Bench for turf_event_fragmenter: randomized events and backpressure,
// expected fragments from a queue-based reference model, decoupled monitors.
module tb_turf_event_fragmenter;
`ifdef TURF_FRAG_HEADER_EN
   localparam int H = 1;
`else
   localparam int H = 0;
`endif

   logic        aclk;
   logic        aresetn;
   logic [63:0] s_evdata_tdata;
   logic        s_evdata_tvalid;
   logic        s_evdata_tready;
   logic        s_evdata_tlast;
   logic [63:0] m_udphdr_tdata;
   logic        m_udphdr_tvalid;
   logic        m_udphdr_tready;
   logic [63:0] m_udpdata_tdata;
   logic [7:0]  m_udpdata_tkeep;
   logic        m_udpdata_tvalid;
   logic        m_udpdata_tready;
   logic        m_udpdata_tlast;
   logic [9:0]  nfragment_count_i;
   logic [31:0] event_ip_i;
   logic [15:0] event_port_i;
   logic        event_open_i;
   logic [15:0] event_number_o;
   logic [15:0] dropped_events_o;

   turf_event_fragmenter #(.BUF_DEPTH(1024)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .s_evdata_tdata   (s_evdata_tdata),
      .s_evdata_tvalid  (s_evdata_tvalid),
      .s_evdata_tready  (s_evdata_tready),
      .s_evdata_tlast   (s_evdata_tlast),
      .m_udphdr_tdata   (m_udphdr_tdata),
      .m_udphdr_tvalid  (m_udphdr_tvalid),
      .m_udphdr_tready  (m_udphdr_tready),
      .m_udpdata_tdata  (m_udpdata_tdata),
      .m_udpdata_tkeep  (m_udpdata_tkeep),
      .m_udpdata_tvalid (m_udpdata_tvalid),
      .m_udpdata_tready (m_udpdata_tready),
      .m_udpdata_tlast  (m_udpdata_tlast),
      .nfragment_count_i(nfragment_count_i),
      .event_ip_i       (event_ip_i),
      .event_port_i     (event_port_i),
      .event_open_i     (event_open_i),
      .event_number_o   (event_number_o),
      .dropped_events_o (dropped_events_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          total = 0;
   int          bad   = 0;
   logic [63:0] hdr_q[$];
   logic [64:0] data_q[$];      // {tlast, tdata}
   logic [15:0] m_evnum = '0;
   logic [15:0] m_drop  = '0;
   bit          bp_en   = 1'b0;

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Reference model: split the event into chunks of nf+1 words.
   task automatic model_event(input logic [63:0] w[$], input int nf, input bit open,
                              input logic [31:0] ip, input logic [15:0] port);
      int n, fsz, nfr, start, len;
      if (!open) begin
         m_drop++;
         return;
      end
      n   = w.size();
      fsz = nf + 1;
      nfr = (n + fsz - 1) / fsz;
      for (int f = 0; f < nfr; f++) begin
         start = f * fsz;
         len   = (n - start < fsz) ? n - start : fsz;
         hdr_q.push_back({ip, port, 16'(8 * (len + H))});
         if (H == 1)
            data_q.push_back({1'b0, 16'(f), m_evnum, 16'(8 * len), 15'd0, (f == nfr - 1)});
         for (int i = 0; i < len; i++) data_q.push_back({(i == len - 1), w[start + i]});
      end
      m_evnum++;
   endtask

   // ---------------- output ready driver ----------------
   initial begin
      m_udphdr_tready  = 1'b0;
      m_udpdata_tready = 1'b0;
      forever begin
         @(posedge aclk);
         #1;
         if (bp_en) begin
            m_udphdr_tready  = 1'($urandom_range(0, 1));
            m_udpdata_tready = 1'($urandom_range(0, 2) != 0);
         end else begin
            m_udphdr_tready  = 1'b1;
            m_udpdata_tready = 1'b1;
         end
      end
   end

   // ---------------- event driver ----------------
   task automatic send_event(input int n, input int nf, input bit open,
                             input logic [31:0] ip, input logic [15:0] port,
                             input bit gaps, input int chg_nf, input int chg_open,
                             output int rdy_cycles);
      logic [63:0] w[$];
      bit hs;
      int cyc;
      for (int i = 0; i < n; i++) w.push_back({$urandom, $urandom});
      model_event(w, nf, open, ip, port);
      rdy_cycles = 0;
      @(posedge aclk);
      #1;
      nfragment_count_i = 10'(nf);
      event_ip_i        = ip;
      event_port_i      = port;
      event_open_i      = open;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            s_evdata_tvalid = 1'b0;
            @(posedge aclk);
            #1;
         end
         s_evdata_tdata  = w[i];
         s_evdata_tlast  = (i == n - 1);
         s_evdata_tvalid = 1'b1;
         hs  = 1'b0;
         cyc = 0;
         while (!hs) begin
            @(negedge aclk);
            if (s_evdata_tready) begin
               hs = 1'b1;
               rdy_cycles++;
            end
            @(posedge aclk);
            #1;
            cyc++;
            if (!hs && cyc > 20000) begin
               chk("input_accept_timeout", 65'(cyc), 65'(0));
               s_evdata_tvalid = 1'b0;
               return;
            end
         end
         if (i == 0) begin
            if (chg_nf >= 0)   nfragment_count_i = 10'(chg_nf);
            if (chg_open >= 0) event_open_i      = 1'(chg_open);
         end
      end
      s_evdata_tvalid = 1'b0;
      s_evdata_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int cyc = 0;
      while ((hdr_q.size() != 0 || data_q.size() != 0) && cyc < 30000) begin
         @(negedge aclk);
         cyc++;
      end
      chk("drain_done", 65'(cyc < 30000), 65'(1));
      repeat (3) @(negedge aclk);
   endtask

   // ---------------- monitors ----------------
   logic        ph_v, ph_hs, pd_v, pd_hs;
   logic [63:0] ph_d;
   logic [64:0] pd_d;
   logic [64:0] exp_v;

   always @(negedge aclk) begin
      if (!aresetn) begin
         ph_v = 1'b0; ph_hs = 1'b0; pd_v = 1'b0; pd_hs = 1'b0;
      end else begin
         if (ph_v && !ph_hs) begin
            chk("hdr_hold_valid", 65'(m_udphdr_tvalid), 65'(1));
            chk("hdr_hold_data", 65'(m_udphdr_tdata), 65'(ph_d));
         end
         if (pd_v && !pd_hs) begin
            chk("data_hold_valid", 65'(m_udpdata_tvalid), 65'(1));
            chk("data_hold_data", {m_udpdata_tlast, m_udpdata_tdata}, pd_d);
         end
         ph_v  = m_udphdr_tvalid;
         ph_d  = m_udphdr_tdata;
         ph_hs = m_udphdr_tvalid && m_udphdr_tready;
         pd_v  = m_udpdata_tvalid;
         pd_d  = {m_udpdata_tlast, m_udpdata_tdata};
         pd_hs = m_udpdata_tvalid && m_udpdata_tready;
         if (ph_hs) begin
            if (hdr_q.size() == 0) begin
               total++; bad++;
               $display("FAIL hdr_unexpected act=%h exp=none", m_udphdr_tdata);
            end else begin
               exp_v = 65'(hdr_q.pop_front());
               chk("udp_hdr", 65'(m_udphdr_tdata), exp_v);
            end
         end
         if (pd_hs) begin
            chk("data_tkeep", 65'(m_udpdata_tkeep), 65'(8'hFF));
            if (data_q.size() == 0) begin
               total++; bad++;
               $display("FAIL data_unexpected act=%h exp=none", {m_udpdata_tlast, m_udpdata_tdata});
            end else begin
               exp_v = data_q.pop_front();
               chk("udp_data", {m_udpdata_tlast, m_udpdata_tdata}, exp_v);
            end
         end
      end
   end

   // ---------------- main sequence ----------------
   int rc;
   int cyc;
   initial begin
      aresetn           = 1'b0;
      s_evdata_tdata    = '0;
      s_evdata_tvalid   = 1'b0;
      s_evdata_tlast    = 1'b0;
      nfragment_count_i = '0;
      event_ip_i        = '0;
      event_port_i      = '0;
      event_open_i      = 1'b0;
      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk("rst_tready", 65'(s_evdata_tready), 65'(0));
      chk("rst_hdr_valid", 65'(m_udphdr_tvalid), 65'(0));
      chk("rst_data_valid", 65'(m_udpdata_tvalid), 65'(0));
      chk("rst_evnum", 65'(event_number_o), 65'(0));
      chk("rst_dropped", 65'(dropped_events_o), 65'(0));
      @(posedge aclk);
      #1;
      aresetn = 1'b1;

      // 10-qword event, 4-qword fragments.
      send_event(10, 3, 1'b1, 32'h0A000001, 16'h1234, 1'b0, -1, -1, rc);
      @(negedge aclk);
      chk("hdr_valid_after_fill", 65'(m_udphdr_tvalid), 65'(1));
      wait_drain();
      chk("evnum_after_10", 65'(event_number_o), 65'(m_evnum));

      // Event ending exactly on a fragment boundary.
      send_event(8, 3, 1'b1, 32'h0A000001, 16'h1234, 1'b0, -1, -1, rc);
      wait_drain();
      chk("evnum_after_8", 65'(event_number_o), 65'(m_evnum));

      // Closed port: event swallowed.
      send_event(5, 3, 1'b0, 32'h0A000001, 16'h1234, 1'b0, -1, -1, rc);
      chk("drop_tready_cycles", 65'(rc), 65'(5));
      @(negedge aclk);
      chk("drop_back_idle", 65'(s_evdata_tready), 65'(0));
      wait_drain();
      chk("dropped_count", 65'(dropped_events_o), 65'(m_drop));
      chk("evnum_after_drop", 65'(event_number_o), 65'(m_evnum));

      // Random backpressure, 37 qwords, 8-qword fragments.
      bp_en = 1'b1;
      send_event(37, 7, 1'b1, 32'hC0A80107, 16'h4321, 1'b1, -1, -1, rc);
      wait_drain();
      bp_en = 1'b0;

      // nfrag change mid-event, then next event uses the new value.
      send_event(10, 3, 1'b1, 32'h0A000002, 16'h0101, 1'b0, 1, -1, rc);
      send_event(5, 1, 1'b1, 32'h0A000002, 16'h0101, 1'b0, -1, -1, rc);
      wait_drain();

      // Port closing mid-event does not truncate it.
      send_event(6, 2, 1'b1, 32'h0A000003, 16'h0202, 1'b0, -1, 0, rc);
      wait_drain();
      chk("evnum_after_close", 65'(event_number_o), 65'(m_evnum));

      // Randomized events.
      for (int e = 0; e < 10; e++) begin
         bp_en = 1'($urandom_range(0, 1));
         send_event(int'($urandom_range(1, 40)), int'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0), $urandom, 16'($urandom),
                    1'b1, -1, -1, rc);
      end
      wait_drain();
      bp_en = 1'b0;
      chk("evnum_after_random", 65'(event_number_o), 65'(m_evnum));
      chk("dropped_after_random", 65'(dropped_events_o), 65'(m_drop));

      // Maximum fragment size.
      send_event(1030, 1023, 1'b1, 32'h0A0000FF, 16'hFFFF, 1'b0, -1, -1, rc);
      wait_drain();

      // Reset during PAYLOAD.
      send_event(6, 7, 1'b1, 32'h0A000004, 16'h0404, 1'b0, -1, -1, rc);
      cyc = 0;
      while (!m_udpdata_tvalid && cyc < 100) begin
         @(negedge aclk);
         cyc++;
      end
      @(negedge aclk);
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_rst_data_valid", 65'(m_udpdata_tvalid), 65'(0));
      chk("async_rst_hdr_valid", 65'(m_udphdr_tvalid), 65'(0));
      chk("async_rst_tready", 65'(s_evdata_tready), 65'(0));
      hdr_q.delete();
      data_q.delete();
      m_evnum = '0;
      m_drop  = '0;
      @(posedge aclk);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("post_rst_evnum", 65'(event_number_o), 65'(0));
      chk("post_rst_dropped", 65'(dropped_events_o), 65'(0));
      send_event(1, 0, 1'b1, 32'h0A000005, 16'h0505, 1'b0, -1, -1, rc);
      wait_drain();
      chk("evnum_after_1q", 65'(event_number_o), 65'(m_evnum));

      chk("hdr_q_empty", 65'(hdr_q.size()), 65'(0));
      chk("data_q_empty", 65'(data_q.size()), 65'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/turf_event_fragmenter.md
# turf_event_fragmenter

Store-and-forward fragmenter sitting directly upstream of the UDP transmit path and downstream of the event control port. It accepts whole events as a 64-bit AXI4-Stream and splits each one into UDP fragments of at most `nfragment_count_i+1` qwords. Fragments go to the event destination (`event_ip_i`:`event_port_i`) as a UDP header beat plus a data stream. Events arriving while the event port is closed are consumed and discarded.

## Interface
- `BUF_DEPTH`, 1024: fragment buffer depth in qwords; must be ≥ 1024 so any 10-bit `nfragment_count_i` fits.
- `aclk` in 1: sole clock.
- `aresetn` in 1: reset, asynchronous, active-low.
- `s_evdata_tdata` in 64: event payload qword.
- `s_evdata_tvalid` in 1: event payload valid.
- `s_evdata_tready` out 1: event payload ready.
- `s_evdata_tlast` in 1: last qword of the event. Events are whole qwords; there is no tkeep.
- `m_udphdr_tdata` out 64: `{dest_ip[31:0], dest_port[15:0], udp_length[15:0]}`.
- `m_udphdr_tvalid` out 1: header valid.
- `m_udphdr_tready` in 1: header ready.
- `m_udpdata_tdata` out 64: fragment data.
- `m_udpdata_tkeep` out 8: always 8'hFF.
- `m_udpdata_tvalid` out 1: fragment data valid.
- `m_udpdata_tready` in 1: fragment data ready.
- `m_udpdata_tlast` out 1: last qword of the fragment.
- `nfragment_count_i` in 10: maximum payload qwords per fragment, minus 1.
- `event_ip_i` in 32: destination IP.
- `event_port_i` in 16: destination port.
- `event_open_i` in 1: event port open.
- `event_number_o` out 16: number of the next event to be sent.
- `dropped_events_o` out 16: count of discarded events; wraps.

## Operation
- Configuration latch: `nfragment_count_i`, `event_ip_i`, `event_port_i` and `event_open_i` are latched at event start (IDLE with `s_evdata_tvalid`=1). Changes mid-event have no effect until the next event.
- States:
  - IDLE: `s_evdata_tready`=0. On `s_evdata_tvalid`, latch config, clear fragment index and word count. Go to FILL if open, else DROP.
  - FILL: `s_evdata_tready`=1. Each accepted qword is written to the buffer at address = word count, and the count increments.
    - Leave to HDR when the accepted word has tlast, or when count reaches nfrag+1.
    - Record `last_frag` = tlast of the final accepted word.
  - HDR: `m_udphdr_tvalid`=1. `udp_length` = 8·(nwords + H) bytes, where H=1 if the header word is enabled, else 0. Advance on `m_udphdr_tready`.
  - FHDR (only if enabled): emit one qword `{frag_index[15:0], event_number[15:0], 8·nwords[15:0], 15'b0, last_frag}` with `tlast`=0. Advance on `m_udpdata_tready`.
  - PAYLOAD: emit buffer words 0..nwords-1 in order; `tlast` on word nwords-1. After the last handshake:
    - if `last_frag`: go to IDLE and increment `event_number`;
    - else: go to FILL with frag_index+1 and word count cleared.
  - DROP: `s_evdata_tready`=1 and data is discarded. On the tlast handshake, increment `dropped_events_o` and go to IDLE.
- Boundary conditions:
  - An event ending exactly on a fragment boundary produces no empty trailing fragment, because tlast marks that fragment as last.
  - A 1-qword event produces one fragment.
  - `nfragment_count_i`=1023 gives 1024-qword fragments.
  - frag_index and event_number wrap at 16 bits.
  - `event_open_i` falling mid-event does not truncate the event.
- Reset: asynchronous clear to IDLE. All tvalid/tready outputs = 0, counters = 0, `event_number_o`=0, `dropped_events_o`=0. After reset, the next input qword is treated as an event start.

## Timing
- `m_udphdr_tvalid` rises the cycle after the final FILL handshake.
- The first data qword is valid no later than 2 cycles after the header handshake.
- With `m_udpdata_tready` held high, payload streams one qword per cycle with no bubbles. The buffer read latency is hidden by a prefetch/skid register.
- AXI rules apply: once asserted, tvalid and tdata hold until the handshake. tvalid never depends on tready.
- Input throughput is one qword per cycle in FILL and DROP. The block does not accept input while draining; there is a single buffer.
- Output `tdata` is registered.

## Configuration
- `TURF_FRAG_HEADER_EN` defined: the FHDR qword is prepended to every fragment and H=1.
- `TURF_FRAG_HEADER_EN` not defined: the FHDR state is removed, payload follows HDR directly, H=0, and `udp_length` = 8·nwords.

## Test plan
- Header enabled; nfrag=3, ip 0x0A000001, port 0x1234, open; one 10-qword event.
  - Expect three fragments of 4/4/2 qwords with `udp_length` 40/40/24.
  - Expect FHDR frag_index 0/1/2, last flag set only on fragment 2, event number 0.
  - Afterwards `event_number_o`=1.
- nfrag=3; one 8-qword event → exactly two fragments of 4 qwords, last flag set on the second; no third fragment.
- `event_open_i`=0; one 5-qword event → `s_evdata_tready` high for 5 cycles, no header, `dropped_events_o`=1, `event_number_o` unchanged.
- Random `m_udpdata_tready` and `m_udphdr_tready` backpressure on a 37-qword event with nfrag=7 → payload is bit-exact and in order, tvalid/tdata stable while stalled, lengths 72×4 and 48.
- nfrag changed from 3 to 1 mid-event → the current event keeps 4-qword fragments; the next event uses 2-qword fragments.
- `aresetn` asserted mid-PAYLOAD → `m_udpdata_tvalid`/`m_udphdr_tvalid` drop immediately with no clock edge; after release, a 1-qword event gives `udp_length`=16 and event number 0.
